// File: rtl/alu_pkg.sv
// ============================================================================
// Module  : alu_pkg
// Purpose : Shared ALUop codes, arbiter FSM states and default widths.
//           Optional feature macro used by this slice: ALU_ARB_RR_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam int DW_DEF  = 32;
    localparam int OPW_DEF = 4;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

endpackage : alu_pkg

`default_nettype wire

// File: rtl/alu_arb_pick.sv
// ============================================================================
// Module  : alu_arb_pick
// Purpose : Two-way grant selection. ALU_ARB_RR_EN selects round-robin,
//           otherwise fixed priority with port 0 winning contention.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_arb_pick
    import alu_pkg::*;
(
    input  logic valid0_i,
    input  logic valid1_i,
`ifdef ALU_ARB_RR_EN
    input  logic last_grant_i,
`endif
    output logic grant_o,
    output logic any_o
);

    assign any_o = valid0_i | valid1_i;

`ifdef ALU_ARB_RR_EN
    // On contention hand the grant to whichever port did not win last time.
    assign grant_o = (valid0_i && valid1_i) ? ~last_grant_i : valid1_i;
`else
    assign grant_o = valid1_i & ~valid0_i;
`endif

endmodule : alu_arb_pick

`default_nettype wire

// File: rtl/alu_arbiter.sv
// ============================================================================
// Module  : alu_arbiter
// Purpose : Two-port arbiter/sequencer for the shared ALU (IDLE->EXEC->RESP).
//           Define ALU_ARB_RR_EN for round-robin, else fixed priority.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_arbiter
    import alu_pkg::*;
#(
    parameter int DW  = DW_DEF,
    parameter int OPW = OPW_DEF
) (
    input  logic           clk,
    input  logic           rst_n,

    input  logic           req0_valid_i,
    output logic           req0_ready_o,
    input  logic [DW-1:0]  req0_a_i,
    input  logic [DW-1:0]  req0_b_i,
    input  logic [OPW-1:0] req0_op_i,

    input  logic           req1_valid_i,
    output logic           req1_ready_o,
    input  logic [DW-1:0]  req1_a_i,
    input  logic [DW-1:0]  req1_b_i,
    input  logic [OPW-1:0] req1_op_i,

    output logic           rsp0_valid_o,
    input  logic           rsp0_ready_i,
    output logic           rsp1_valid_o,
    input  logic           rsp1_ready_i,
    output logic [DW-1:0]  rsp_result_o,
    output logic           rsp_zero_o,

    output logic [DW-1:0]  alu_srca_o,
    output logic [DW-1:0]  alu_srcb_o,
    output logic [OPW-1:0] alu_op_o,
    input  logic [DW-1:0]  alu_result_i,
    input  logic           alu_zero_i,

    output logic           busy_o
);

    arb_state_t     state_q, state_d;
    logic [DW-1:0]  a_q, a_d;
    logic [DW-1:0]  b_q, b_d;
    logic [OPW-1:0] op_q, op_d;
    logic           tag_q, tag_d;
    logic [DW-1:0]  result_q, result_d;
    logic           zero_q, zero_d;
    logic           grant;
    logic           any;
    logic           idle;
    logic           rsp_taken;

`ifdef ALU_ARB_RR_EN
    logic           last_grant_q, last_grant_d;
`endif

    alu_arb_pick u_pick (
        .valid0_i     (req0_valid_i),
        .valid1_i     (req1_valid_i),
`ifdef ALU_ARB_RR_EN
        .last_grant_i (last_grant_q),
`endif
        .grant_o      (grant),
        .any_o        (any)
    );

    assign idle      = (state_q == IDLE);
    assign rsp_taken = tag_q ? rsp1_ready_i : rsp0_ready_i;

    // Readies are masked by reset so nothing looks accepted while held in reset.
    assign req0_ready_o = rst_n & idle & any & ~grant;
    assign req1_ready_o = rst_n & idle & any &  grant;

    assign rsp0_valid_o = (state_q == RESP) & ~tag_q;
    assign rsp1_valid_o = (state_q == RESP) &  tag_q;
    assign rsp_result_o = result_q;
    assign rsp_zero_o   = zero_q;

    assign alu_srca_o   = a_q;
    assign alu_srcb_o   = b_q;
    assign alu_op_o     = op_q;

    assign busy_o       = ~idle;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        tag_d    = tag_q;
        result_d = result_q;
        zero_d   = zero_q;
`ifdef ALU_ARB_RR_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            IDLE: begin
                if (any) begin
                    a_d     = grant ? req1_a_i  : req0_a_i;
                    b_d     = grant ? req1_b_i  : req0_b_i;
                    op_d    = grant ? req1_op_i : req0_op_i;
                    tag_d   = grant;
`ifdef ALU_ARB_RR_EN
                    last_grant_d = grant;
`endif
                    state_d = EXEC;
                end
            end
            EXEC: begin
                result_d = alu_result_i;
                zero_d   = alu_zero_i;
                state_d  = RESP;
            end
            RESP: begin
                if (rsp_taken) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            tag_q    <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
`ifdef ALU_ARB_RR_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            tag_q    <= tag_d;
            result_q <= result_d;
            zero_q   <= zero_d;
`ifdef ALU_ARB_RR_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

endmodule : alu_arbiter

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ============================================================================
// Module  : tb_alu_arbiter
// Purpose : Self-checking bench for alu_arbiter; honours ALU_ARB_RR_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int DW  = 32;
    localparam int OPW = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           req0_valid = 1'b0, req1_valid = 1'b0;
    logic [DW-1:0]  req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [OPW-1:0] req0_op = '0, req1_op = '0;
    logic           rsp0_ready = 1'b0, rsp1_ready = 1'b0;
    logic           req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_zero, busy;
    logic [DW-1:0]  rsp_result, alu_srca, alu_srcb, alu_result;
    logic [OPW-1:0] alu_op;
    logic           alu_zero;

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] ref_alu(input logic [OPW-1:0] op,
                                              input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
        case (op)
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            default: return '0;
        endcase
    endfunction

    // The ALU lives outside the arbiter; the bench plays its part.
    assign alu_result = ref_alu(alu_op, alu_srca, alu_srcb);
    assign alu_zero   = (alu_result == '0);

    alu_arbiter #(.DW(DW), .OPW(OPW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req0_valid_i (req0_valid),
        .req0_ready_o (req0_ready),
        .req0_a_i     (req0_a),
        .req0_b_i     (req0_b),
        .req0_op_i    (req0_op),
        .req1_valid_i (req1_valid),
        .req1_ready_o (req1_ready),
        .req1_a_i     (req1_a),
        .req1_b_i     (req1_b),
        .req1_op_i    (req1_op),
        .rsp0_valid_o (rsp0_valid),
        .rsp0_ready_i (rsp0_ready),
        .rsp1_valid_o (rsp1_valid),
        .rsp1_ready_i (rsp1_ready),
        .rsp_result_o (rsp_result),
        .rsp_zero_o   (rsp_zero),
        .alu_srca_o   (alu_srca),
        .alu_srcb_o   (alu_srcb),
        .alu_op_o     (alu_op),
        .alu_result_i (alu_result),
        .alu_zero_i   (alu_zero),
        .busy_o       (busy)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    // Reference model: one outstanding operation, response two cycles after
    // its handshake, served until the owning port takes it.
    bit             m_out = 1'b0;
    int             m_port = 0;
    int             m_age = 0;
    logic [DW-1:0]  m_a, m_b, m_res;
    logic [OPW-1:0] m_op;
`ifdef ALU_ARB_RR_EN
    bit             m_last = 1'b1;
`endif
    bit             hs0, hs1;
    logic [DW-1:0]  hs_a0, hs_b0;
    int             served_q[$];
    logic [DW-1:0]  res_q[$];
    logic           zero_q[$];

    task automatic model_reset();
        m_out = 1'b0;
        m_age = 0;
`ifdef ALU_ARB_RR_EN
        m_last = 1'b1;
`endif
    endtask

    // Entered at posedge+1 with inputs already driven; returns at the next posedge+1.
    task automatic step();
        bit e_r0, e_r1, e_v0, e_v1;
        int w;
        #4;
        hs0 = 1'b0;
        hs1 = 1'b0;
        if (m_out) m_age++;
        e_r0 = 1'b0;
        e_r1 = 1'b0;
        if (!m_out && (req0_valid || req1_valid)) begin
            if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_RR_EN
                w = m_last ? 0 : 1;
`else
                w = 0;
`endif
            end else begin
                w = req1_valid ? 1 : 0;
            end
            if (w == 0) e_r0 = 1'b1;
            else        e_r1 = 1'b1;
        end
        e_v0 = m_out && m_age >= 2 && m_port == 0;
        e_v1 = m_out && m_age >= 2 && m_port == 1;
        check("req0_ready", req0_ready, e_r0);
        check("req1_ready", req1_ready, e_r1);
        check("rsp0_valid", rsp0_valid, e_v0);
        check("rsp1_valid", rsp1_valid, e_v1);
        check("busy", busy, m_out);
        if (m_out && m_age == 1) begin
            check("alu_srca", alu_srca, m_a);
            check("alu_srcb", alu_srcb, m_b);
            check("alu_op", alu_op, m_op);
        end
        if (e_v0 || e_v1) begin
            check("rsp_result", rsp_result, m_res);
            check("rsp_zero", rsp_zero, m_res == '0);
        end
        if (!m_out && (e_r0 || e_r1)) begin
            m_out  = 1'b1;
            m_age  = 0;
            m_port = e_r1 ? 1 : 0;
            m_a    = e_r1 ? req1_a  : req0_a;
            m_b    = e_r1 ? req1_b  : req0_b;
            m_op   = e_r1 ? req1_op : req0_op;
            m_res  = ref_alu(m_op, m_a, m_b);
`ifdef ALU_ARB_RR_EN
            m_last = e_r1;
`endif
            hs0 = e_r0;
            hs1 = e_r1;
            if (e_r0) begin
                hs_a0 = req0_a;
                hs_b0 = req0_b;
            end
        end else if ((e_v0 && rsp0_ready) || (e_v1 && rsp1_ready)) begin
            served_q.push_back(rsp1_valid ? 1 : 0);
            res_q.push_back(rsp_result);
            zero_q.push_back(rsp_zero);
            m_out = 1'b0;
        end
        @(posedge clk);
        #1;
        if (hs0) req0_valid = 1'b0;
        if (hs1) req1_valid = 1'b0;
    endtask

    task automatic drain(input int limit);
        int n;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        n = 0;
        while ((m_out || req0_valid || req1_valid) && n < limit) begin
            step();
            n++;
        end
        if (n >= limit) check("drain_timeout", 32'd1, 32'd0);
    endtask

    task automatic set0(input logic [OPW-1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        req0_op = op; req0_a = a; req0_b = b; req0_valid = 1'b1;
    endtask

    task automatic set1(input logic [OPW-1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        req1_op = op; req1_a = a; req1_b = b; req1_valid = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int base;
        bit got0;

        // Reset values
        #3;
        check("rst_busy", busy, 1'b0);
        check("rst_ready0", req0_ready, 1'b0);
        check("rst_ready1", req1_ready, 1'b0);
        check("rst_rsp0v", rsp0_valid, 1'b0);
        check("rst_rsp1v", rsp1_valid, 1'b0);
        check("rst_result", rsp_result, 32'd0);
        check("rst_zero", rsp_zero, 1'b0);
        check("rst_srca", alu_srca, 32'd0);
        check("rst_op", alu_op, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Port 0 ADD 5+3
        set0(ALU_ADD, 32'd5, 32'd3);
        drain(20);
        check("t1_result", res_q[res_q.size()-1], 32'd8);
        check("t1_zero", zero_q[zero_q.size()-1], 1'b0);
        check("t1_port", served_q[served_q.size()-1], 32'd0);

        // Port 1 SUB 7-7
        set1(ALU_SUB, 32'd7, 32'd7);
        drain(20);
        check("t2_result", res_q[res_q.size()-1], 32'd0);
        check("t2_zero", zero_q[zero_q.size()-1], 1'b1);
        check("t2_port", served_q[served_q.size()-1], 32'd1);

        // Contention straight out of reset
        do_reset();
        base = served_q.size();
        set0(ALU_ADD, 32'd1, 32'd1);
        set1(ALU_ADD, 32'd2, 32'd2);
        drain(30);
        check("t3_count", served_q.size() - base, 32'd2);
        check("t3_first", served_q[base], 32'd0);
        check("t3_res0", res_q[base], 32'd2);
        check("t3_res1", res_q[base+1], 32'd4);

        // Sustained contention: both ports re-request immediately
        base = served_q.size();
        set0(ALU_OR, 32'h10, 32'h01);
        set1(ALU_AND, 32'hff, 32'h0f);
        for (int i = 0; i < 100 && served_q.size() - base < 6; i++) begin
            step();
            if (hs0) set0(ALU_ADD, $urandom, $urandom);
            if (hs1) set1(ALU_SUB, $urandom, $urandom);
        end
        drain(100);
        check("t3b_count", (served_q.size() - base >= 6) ? 32'd1 : 32'd0, 32'd1);
        for (int k = 0; k < 6; k++) begin
`ifdef ALU_ARB_RR_EN
            check("t3b_order", served_q[base+k], k % 2);
`else
            check("t3b_order", served_q[base+k], 32'd0);
`endif
        end

        // Response back-pressure holds the arbiter
        base = served_q.size();
        rsp0_ready = 1'b0;
        set0(ALU_ADD, 32'h1234, 32'h1111);
        for (int i = 0; i < 10 && !(m_out && m_age >= 2); i++) step();
        set1(ALU_OR, 32'hf0, 32'h0f);
        for (int i = 0; i < 4; i++) step();
        check("t4_busy", busy, 1'b1);
        check("t4_ready1", req1_ready, 1'b0);
        drain(20);
        check("t4_count", served_q.size() - base, 32'd2);
        check("t4_order0", served_q[base], 32'd0);
        check("t4_order1", served_q[base+1], 32'd1);

        // Reset while an operation is in EXEC
        base = served_q.size();
        set0(ALU_ADD, 32'd40, 32'd2);
        step();
        set1(ALU_SUB, 32'd9, 32'd4);
        rst_n = 1'b0;
        #1;
        check("t5_busy", busy, 1'b0);
        check("t5_rsp0v", rsp0_valid, 1'b0);
        check("t5_rsp1v", rsp1_valid, 1'b0);
        check("t5_ready1", req1_ready, 1'b0);
        check("t5_srca", alu_srca, 32'd0);
        check("t5_result", rsp_result, 32'd0);
        model_reset();
        set0(ALU_ADD, 32'd40, 32'd2);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drain(30);
        check("t5_count", served_q.size() - base, 32'd2);
        check("t5_res0", res_q[base], 32'd42);

        // Operands of a waiting request change until its handshake
        rsp1_ready = 1'b0;
        set1(ALU_ADD, 32'd3, 32'd4);
        step();
        set0(ALU_ADD, 32'd0, 32'd100);
        got0 = 1'b0;
        for (int i = 0; i < 40 && !got0; i++) begin
            if (i == 5) rsp1_ready = 1'b1;
            req0_a = $urandom;
            step();
            if (hs0) got0 = 1'b1;
        end
        check("t6_hs", got0, 1'b1);
        drain(20);
        check("t6_result", res_q[res_q.size()-1], hs_a0 + hs_b0);

        // Randomised traffic with random response back-pressure
        for (int i = 0; i < 400; i++) begin
            if (!req0_valid && $urandom_range(2) == 0)
                set0(OPW'($urandom_range(3)), $urandom_range(15), $urandom_range(15));
            if (!req1_valid && $urandom_range(2) == 0)
                set1(OPW'($urandom_range(3)), $urandom, $urandom_range(3) == 0 ? req1_a : $urandom);
            if (req0_valid && $urandom_range(5) == 0) req0_b = $urandom_range(15);
            rsp0_ready = ($urandom_range(9) < 7);
            rsp1_ready = ($urandom_range(9) < 7);
            step();
        end
        drain(50);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule : tb_alu_arbiter

`default_nettype wire
